// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the arbiter's three request/response groups into one interface:
//     fetch side  : i_req, i_adr -> i_rdata, i_ready
//     data side   : d_req, d_we, d_adr, d_wdata -> d_rdata, d_ready
//     memory side : m_req, m_we, m_adr, m_wdata <- m_rdata, m_ack
//   Modports:
//     master : the arbiter itself (drives ready/rdata and the m_* request)
//     slave  : the core requesters plus the memory model around it
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             i_req;
    logic [WIDTH-1:0] i_adr;
    logic [WIDTH-1:0] i_rdata;
    logic             i_ready;

    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_adr;
    logic [WIDTH-1:0] d_wdata;
    logic [WIDTH-1:0] d_rdata;
    logic             d_ready;

    logic             m_req;
    logic             m_we;
    logic [WIDTH-1:0] m_adr;
    logic [WIDTH-1:0] m_wdata;
    logic [WIDTH-1:0] m_rdata;
    logic             m_ack;

    modport master (
        input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_adr, m_wdata
    );

    modport slave (
        output i_req, i_adr, d_req, d_we, d_adr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_adr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Serialises instruction-fetch and load/store requests onto one memory
//   port. Flow per transfer: IDLE (grant, latch request) -> BUSY (m_req
//   held, wait for m_ack) -> RESP (one-cycle ready pulse to the owner).
//   A watchdog aborts a BUSY phase that lasts TIMEOUT cycles without an
//   ack, returning 32'hDEADBEEF and raising the sticky err flag.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : mem_port_arbiter_if.master (fetch, data and memory groups)
//   err    : sticky watchdog timeout flag, cleared only by reset
//
// Parameters:
//   WIDTH   : address/data width
//   TIMEOUT : BUSY cycles without m_ack before abort; 0 disables watchdog
//
// Build option:
//   ARB_ROUND_ROBIN_EN : when defined, simultaneous requests alternate
//                        between the two requesters instead of data always
//                        winning.
module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus,
    output logic               err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_DATA  = 1'b0;
    localparam logic OWN_FETCH = 1'b1;

    // Counter just wide enough to reach TIMEOUT.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0]       state_q,   state_d;
    logic             owner_q,   owner_d;
    logic [WD_W-1:0]  wd_q,      wd_d;
    logic             err_q,     err_d;
    logic             m_we_q,    m_we_d;
    logic [WIDTH-1:0] m_adr_q,   m_adr_d;
    logic [WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic             pick_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // Data wins unless both are requesting and data had the previous grant.
    assign pick_data = bus.d_req && (!bus.i_req || (last_owner_q == OWN_FETCH));
`else
    assign pick_data = bus.d_req;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wd_d      = wd_q;
        err_d     = err_q;
        m_we_d    = m_we_q;
        m_adr_d   = m_adr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pick_data) begin
                    owner_d   = OWN_DATA;
                    m_we_d    = bus.d_we;
                    m_adr_d   = bus.d_adr;
                    m_wdata_d = bus.d_wdata;
                    state_d   = S_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = OWN_DATA;
`endif
                end else if (bus.i_req) begin
                    owner_d = OWN_FETCH;
                    m_we_d  = 1'b0;
                    m_adr_d = bus.i_adr;
                    state_d = S_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = OWN_FETCH;
`endif
                end
            end

            S_BUSY: begin
                if (bus.m_ack) begin
                    if (owner_q == OWN_FETCH) begin
                        i_rdata_d = bus.m_rdata;
                    end else begin
                        // Stores return zero so stale read data never leaks out.
                        d_rdata_d = m_we_q ? '0 : bus.m_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if ((TIMEOUT != 0) && (wd_d == WD_W'(TIMEOUT))) begin
                        err_d = 1'b1;
                        if (owner_q == OWN_FETCH) begin
                            i_rdata_d = WIDTH'(32'hDEADBEEF);
                        end else begin
                            d_rdata_d = WIDTH'(32'hDEADBEEF);
                        end
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                wd_d    = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_DATA;
            wd_q      <= '0;
            err_q     <= 1'b0;
            m_we_q    <= 1'b0;
            m_adr_q   <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_FETCH;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            m_we_q    <= m_we_d;
            m_adr_q   <= m_adr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Handshake outputs decode straight from registered state.
    assign bus.m_req   = (state_q == S_BUSY);
    assign bus.i_ready = (state_q == S_RESP) && (owner_q == OWN_FETCH);
    assign bus.d_ready = (state_q == S_RESP) && (owner_q == OWN_DATA);
    assign bus.m_we    = m_we_q;
    assign bus.m_adr   = m_adr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign err         = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench. Two arbiters share clock and reset: "dut" with the
//   default watchdog and "wdut" with TIMEOUT=4 for the abort scenario.
//   Inputs are driven and outputs sampled 1 time unit after each rising
//   edge.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    logic err;
    logic werr;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.WIDTH(32)) bus  ();
    mem_port_arbiter_if #(.WIDTH(32)) wbus ();

    mem_port_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .err   (err)
    );

    mem_port_arbiter #(.WIDTH(32), .TIMEOUT(4)) wdut (
        .clk   (clk),
        .reset (reset),
        .bus   (wbus),
        .err   (werr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_data;
        total = 0;
        bad   = 0;

        reset = 1'b1;
        bus.i_req = 0;  bus.i_adr = 0;  bus.d_req = 0;  bus.d_we = 0;
        bus.d_adr = 0;  bus.d_wdata = 0; bus.m_rdata = 0; bus.m_ack = 0;
        wbus.i_req = 0; wbus.i_adr = 0; wbus.d_req = 0; wbus.d_we = 0;
        wbus.d_adr = 0; wbus.d_wdata = 0; wbus.m_rdata = 0; wbus.m_ack = 0;
        tick();
        tick();

        // Reset state
        chk("rst_m_req",   32'(bus.m_req),   0);
        chk("rst_i_ready", 32'(bus.i_ready), 0);
        chk("rst_d_ready", 32'(bus.d_ready), 0);
        chk("rst_m_we",    32'(bus.m_we),    0);
        chk("rst_m_adr",   bus.m_adr,        0);
        chk("rst_m_wdata", bus.m_wdata,      0);
        chk("rst_i_rdata", bus.i_rdata,      0);
        chk("rst_d_rdata", bus.d_rdata,      0);
        chk("rst_err",     32'(err),         0);
        chk("rst_werr",    32'(werr),        0);
        reset = 1'b0;

        // Fetch with memory acking in the first BUSY cycle
        bus.i_req = 1; bus.i_adr = 0; bus.m_rdata = 32'h20020005; bus.m_ack = 1;
        tick();
        chk("fetch_m_req",   32'(bus.m_req),   1);
        chk("fetch_m_adr",   bus.m_adr,        0);
        chk("fetch_m_we",    32'(bus.m_we),    0);
        chk("fetch_early",   32'(bus.i_ready), 0);
        tick();
        chk("fetch_ready",   32'(bus.i_ready), 1);
        chk("fetch_rdata",   bus.i_rdata,      32'h20020005);
        chk("fetch_m_req_0", 32'(bus.m_req),   0);
        chk("fetch_no_d",    32'(bus.d_ready), 0);
        bus.i_req = 0;
        tick();
        chk("fetch_pulse1",  32'(bus.i_ready), 0);
        chk("fetch_hold",    bus.i_rdata,      32'h20020005);

        // Store: ack one cycle into BUSY, load data must not be captured
        bus.d_req = 1; bus.d_we = 1; bus.d_adr = 84; bus.d_wdata = 7;
        bus.m_ack = 0; bus.m_rdata = 32'h12345678;
        tick();
        chk("st_m_req",   32'(bus.m_req), 1);
        chk("st_m_we",    32'(bus.m_we),  1);
        chk("st_m_adr",   bus.m_adr,      84);
        chk("st_m_wdata", bus.m_wdata,    7);
        bus.m_ack = 1;
        tick();
        chk("st_ready",   32'(bus.d_ready), 1);
        chk("st_rdata",   bus.d_rdata,      0);
        chk("st_no_i",    32'(bus.i_ready), 0);
        bus.d_req = 0; bus.d_we = 0; bus.m_ack = 0;
        tick();
        chk("st_pulse1",  32'(bus.d_ready), 0);

        // Load at 18 with ack in the fifth BUSY cycle; d_adr wiggles meanwhile
        bus.d_req = 1; bus.d_we = 0; bus.d_adr = 18; bus.m_rdata = 21;
        tick();
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("ld_m_adr_%0d", i), bus.m_adr, 18);
            chk($sformatf("ld_busy_%0d", i),  32'(bus.m_req),   1);
            chk($sformatf("ld_wait_%0d", i),  32'(bus.d_ready), 0);
            bus.d_adr = 32'(99 + i);
            if (i == 5) bus.m_ack = 1;
            tick();
        end
        chk("ld_ready", 32'(bus.d_ready), 1);
        chk("ld_rdata", bus.d_rdata,      21);
        chk("ld_err",   32'(err),         0);
        bus.d_req = 0; bus.m_ack = 0;
        tick();
        chk("ld_pulse1", 32'(bus.d_ready), 0);
        chk("ld_hold",   bus.d_rdata,      21);

        // Watchdog on the TIMEOUT=4 instance
        wbus.d_req = 1; wbus.d_we = 0; wbus.d_adr = 5; wbus.m_rdata = 32'h11111111;
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("wd_busy_%0d", i), 32'(wbus.m_req),   1);
            chk($sformatf("wd_wait_%0d", i), 32'(wbus.d_ready), 0);
            chk($sformatf("wd_err0_%0d", i), 32'(werr),         0);
            tick();
        end
        chk("wd_ready", 32'(wbus.d_ready), 1);
        chk("wd_rdata", wbus.d_rdata,      32'hDEADBEEF);
        chk("wd_err",   32'(werr),         1);
        chk("wd_m_req", 32'(wbus.m_req),   0);
        wbus.d_req = 0;
        tick();
        chk("wd_pulse1",   32'(wbus.d_ready), 0);
        chk("wd_sticky1",  32'(werr),         1);
        tick();
        chk("wd_sticky2",  32'(werr),         1);
        reset = 1;
        tick();
        reset = 0;
        chk("wd_err_clr",  32'(werr),         0);

        // Reset while BUSY, then a stray ack in IDLE
        bus.d_req = 1; bus.d_we = 1; bus.d_adr = 32'h40; bus.d_wdata = 32'h55;
        tick();
        chk("rb_busy", 32'(bus.m_req), 1);
        reset = 1; bus.d_req = 0; bus.d_we = 0;
        tick();
        reset = 0;
        chk("rb_m_req",   32'(bus.m_req),   0);
        chk("rb_err",     32'(err),         0);
        chk("rb_d_ready", 32'(bus.d_ready), 0);
        chk("rb_m_adr",   bus.m_adr,        0);
        bus.m_ack = 1;
        tick();
        chk("rb_ack_d",   32'(bus.d_ready), 0);
        chk("rb_ack_i",   32'(bus.i_ready), 0);
        chk("rb_ack_req", 32'(bus.m_req),   0);
        tick();
        chk("rb_ack_d2",  32'(bus.d_ready), 0);
        bus.m_ack = 0;

        // Both requesting continuously, ack in the second BUSY cycle
        bus.i_req = 1; bus.i_adr = 32'h100;
        bus.d_req = 1; bus.d_we = 0; bus.d_adr = 32'h200; bus.m_rdata = 32'hA5;
        for (int g = 0; g < 6; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_data = (g % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            tick();
            chk($sformatf("arb_req_%0d", g), 32'(bus.m_req), 1);
            chk($sformatf("arb_adr_%0d", g), bus.m_adr, exp_data ? 32'h200 : 32'h100);
            tick();
            bus.m_ack = 1;
            tick();
            chk($sformatf("arb_dr_%0d", g), 32'(bus.d_ready), 32'(exp_data));
            chk($sformatf("arb_ir_%0d", g), 32'(bus.i_ready), 32'(!exp_data));
            bus.m_ack = 0;
            tick();
            chk($sformatf("arb_idle_%0d", g), 32'(bus.m_req), 0);
        end
        bus.i_req = 0; bus.d_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the MIPS instruction-fetch path and the load/store data path. It sits between the core and the memory model inside top. Requests are serialised with fixed data-over-fetch priority. Each requester gets a one-cycle ready pulse carrying read data. A watchdog aborts a transfer when memory never acknowledges.

Parameters:
WIDTH, 32, address and data width in bits.
TIMEOUT, 255, maximum cycles spent in BUSY waiting for m_ack; 0 disables the watchdog.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_req  input  1  fetch request; held high until i_ready
i_adr  input  WIDTH  fetch address
i_rdata  output  WIDTH  fetched word, valid while i_ready=1
i_ready  output  1  one-cycle completion pulse for fetch
d_req  input  1  data request; held high until d_ready
d_we  input  1  1=store, 0=load
d_adr  input  WIDTH  data address
d_wdata  input  WIDTH  store data
d_rdata  output  WIDTH  load data, valid while d_ready=1
d_ready  output  1  one-cycle completion pulse for data
m_req  output  1  memory request, high throughout BUSY
m_we  output  1  memory write enable, valid with m_req
m_adr  output  WIDTH  memory address, valid with m_req
m_wdata  output  WIDTH  memory write data, valid with m_req
m_rdata  input  WIDTH  memory read data, sampled when m_ack=1
m_ack  input  1  memory completion, sampled only in BUSY
err  output  1  sticky watchdog-timeout flag

Behaviour:
- Reset, synchronous, active-high: state=IDLE. All outputs 0: i_ready, d_ready, m_req, m_we, m_adr, m_wdata, i_rdata, d_rdata, err. Watchdog counter=0, owner=data. Reset mid-transfer drops m_req at the next edge with no ready pulse.
- States: IDLE, BUSY, RESP.
- IDLE:
  - d_req=1 → owner=data; latch d_adr, d_we, d_wdata into the m_* registers; go to BUSY.
  - else i_req=1 → owner=fetch; latch i_adr, m_we=0; go to BUSY.
  - else stay in IDLE.
  - Simultaneous requests: data wins and fetch waits.
- BUSY:
  - m_req=1; m_* outputs are registered and stable.
  - m_ack=1 → capture m_rdata into the owner's rdata register. For stores, d_rdata is set to 0. Go to RESP.
  - m_ack=0 → increment the watchdog. If TIMEOUT≠0 and the count reaches TIMEOUT: set err=1, owner's rdata=32'hDEADBEEF, go to RESP.
- RESP:
  - m_req=0; the owner's ready=1 for exactly this cycle; go to IDLE.
  - Requests are ignored in RESP, so a requester must drop or change its request in the ready cycle.
  - The watchdog clears.
- Latency: request seen at edge N → m_req high after edge N → ready high one cycle after the ack edge. With m_ack tied high this is 3 cycles per transfer and a 1-cycle idle gap.
- m_ack outside BUSY is ignored.
- rdata registers hold their value after the ready pulse until the next capture.
- Requester address or data changes during BUSY have no effect; values were latched at grant.
- err is cleared only by reset.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: a last_owner register is added, reset to fetch. When both requests are high in IDLE, the requester other than last_owner wins, so the grants alternate. A single request behaves as in the base design.
- Undefined: fixed data-over-fetch priority as described above, and no last_owner register.

Test Plan:
- Memory acks in the first BUSY cycle with m_rdata=32'h20020005. i_req=1, i_adr=0 → m_req high 1 cycle later, m_adr=0, m_we=0. i_ready pulses for 1 cycle with i_rdata=32'h20020005.
- Store: d_req=1, d_we=1, d_adr=84, d_wdata=7 → m_we=1, m_adr=84, m_wdata=7 in BUSY. After the ack, d_ready=1 and d_rdata=0.
- Both requests high every cycle, memory acks with 2-cycle delay:
  - without the macro: only data grants occur, fetch is starved;
  - with ARB_ROUND_ROBIN_EN: the first grant is data, then the grants alternate fetch/data, checked over 6 grants.
- TIMEOUT=4 and m_ack held 0 → after 4 BUSY cycles err=1 and the owner's ready pulses with rdata=32'hDEADBEEF. err remains 1 until reset.
- Assert reset for 1 cycle while in BUSY → m_req=0 and err=0 after the edge, and no ready pulse appears. A later m_ack in IDLE causes no ready pulse.
- Load at address 18 returns 21 with a 5-cycle ack delay → d_ready appears exactly 1 cycle after the ack edge, with d_rdata=21. m_adr stays at 18 for all 5 BUSY cycles even though d_adr changes during BUSY.
